cnt_step_monitor: RTL

- Downstream checker/tracker for the signed 10-bit up/down counter output. Samples the counter value on a qualifier strobe and classifies each step by its delta.
- Steps classified: +5 inc, -9 dec, +10 jump over INV, -18 jump over INV, 0 hold at limit, direction reversal, illegal.
- Tracks running min/max. Pushes notable step events into a small first-word-fall-through (FWFT) FIFO, drained through a valid/ready interface by the debug/log stage.

---
 rtl/cnt_mon_pkg.sv | 44 ++++
 rtl/cnt_mon_fifo.sv | 47 ++++
 rtl/cnt_step_monitor.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cnt_mon_pkg.sv
// Shared types and constants for the counter step monitor.
// Optional STEP_STATS_EN adds per-class step counters to the top.
package cnt_mon_pkg;

    typedef enum logic [2:0] {
        C_INC  = 3'd0,
        C_DEC  = 3'd1,
        C_JUP  = 3'd2,
        C_JDN  = 3'd3,
        C_HOLD = 3'd4,
        C_REV  = 3'd5,
        C_ILL  = 3'd6
    } cls_e;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_TRACK = 2'd1,
        S_ERR   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SG_NONE = 2'd0,
        SG_POS  = 2'd1,
        SG_NEG  = 2'd2
    } sgn_e;

    localparam int EV_W = 13;

    localparam logic signed [9:0] CNT_MIN  = -10'sd230;
    localparam logic signed [9:0] CNT_MAX  = 10'sd235;
    localparam logic signed [9:0] CNT_INV  = -10'sd11;
    localparam logic signed [9:0] JUP_FROM = -10'sd16;
    localparam logic signed [9:0] JDN_FROM = -10'sd2;

    localparam logic signed [10:0] D_INC = 11'sd5;
    localparam logic signed [10:0] D_DEC = 11'sd9;
    localparam logic signed [10:0] D_JUP = 11'sd10;
    localparam logic signed [10:0] D_JDN = 11'sd18;

    function automatic logic signed [10:0] sext(input logic signed [9:0] v);
        return {v[9], v};
    endfunction

endpackage

// File: rtl/cnt_mon_fifo.sv
// First-word-fall-through event FIFO; output reads 0 while empty.
// drop_o pulses when a push is refused because the FIFO is full.
module cnt_mon_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         drop_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp_q, rp_q;
    logic         full, do_pop, do_push;

    assign empty_o = (wp_q == rp_q);
    assign full    = (wp_q[AW] != rp_q[AW]) &&
                     (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && full && !do_pop;
    assign data_o  = empty_o ? '0 : mem[rp_q[AW-1:0]];

    // Pointer bookkeeping; the extra MSB distinguishes full from empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + (AW+1)'(1);
            if (do_pop)  rp_q <= rp_q + (AW+1)'(1);
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem[wp_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/cnt_step_monitor.sv
// Classifies counter steps, tracks min/max and queues notable events.
// Define STEP_STATS_EN to add hold/jump/reversal counters.
module cnt_step_monitor
    import cnt_mon_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter bit EMIT_ALL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  cnt_i,
    input  logic        cnt_vld_i,
    input  logic        clr_i,
    output logic        ev_valid_o,
    input  logic        ev_ready_i,
    output logic [12:0] ev_data_o,
    output logic [9:0]  min_o,
    output logic [9:0]  max_o,
    output logic        trk_vld_o,
    output logic        err_o,
    output logic [7:0]  drop_cnt_o
`ifdef STEP_STATS_EN
   ,output logic [15:0] hold_cnt_o,
    output logic [15:0] jump_cnt_o,
    output logic [15:0] rev_cnt_o
`endif
);

    state_e             state_q, state_d;
    sgn_e               sgn_q;
    cls_e               cls, ev_cls;
    logic signed [9:0]  smp, prev_q, min_q, max_q;
    logic signed [10:0] delta;
    logic               bad_val, emit, push, drop, empty;
    logic               trk_q, err_q;
    logic [7:0]         drop_q;

    assign smp     = $signed(cnt_i);
    assign delta   = sext(smp) - sext(prev_q);
    assign bad_val = (smp < CNT_MIN) || (smp > CNT_MAX) ||
                     (smp == CNT_INV);
    assign emit    = EMIT_ALL || !(cls == C_INC || cls == C_DEC);

    // Step classification; ILL dominates every other class
    always_comb begin
        cls = C_ILL;
        if (bad_val)
            cls = C_ILL;
        else if (delta == '0)
            cls = C_HOLD;
        else if (delta == D_INC)
            cls = (sgn_q == SG_NEG) ? C_REV : C_INC;
        else if (delta == -D_DEC)
            cls = (sgn_q == SG_POS) ? C_REV : C_DEC;
        else if (delta == D_JUP && prev_q == JUP_FROM)
            cls = C_JUP;
        else if (delta == -D_JDN && prev_q == JDN_FROM)
            cls = C_JDN;
    end

    // Next state and event push decision
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        ev_cls  = cls;
        if (clr_i) begin
            state_d = S_EMPTY;
        end else if (cnt_vld_i) begin
            unique case (state_q)
                S_EMPTY: begin
                    ev_cls  = C_ILL;
                    push    = bad_val;
                    state_d = bad_val ? S_ERR : S_TRACK;
                end
                S_TRACK: begin
                    push = emit;
                    if (cls == C_ILL) state_d = S_ERR;
                end
                S_ERR: begin
                    push = emit;
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_EMPTY;
        else     state_q <= state_d;
    end

    // Tracking datapath: previous sample, step sign, min/max, flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            sgn_q  <= SG_NONE;
            min_q  <= '0;
            max_q  <= '0;
            trk_q  <= 1'b0;
            err_q  <= 1'b0;
        end else if (clr_i) begin
            prev_q <= '0;
            sgn_q  <= SG_NONE;
            min_q  <= '0;
            max_q  <= '0;
            trk_q  <= 1'b0;
            err_q  <= 1'b0;
        end else if (cnt_vld_i) begin
            prev_q <= smp;
            if (state_q == S_EMPTY) begin
                sgn_q <= SG_NONE;
                if (bad_val) begin
                    err_q <= 1'b1;
                end else begin
                    min_q <= smp;
                    max_q <= smp;
                    trk_q <= 1'b1;
                end
            end else begin
                if (delta != '0)
                    sgn_q <= delta[10] ? SG_NEG : SG_POS;
                if (state_q == S_TRACK) begin
                    if (cls == C_ILL) begin
                        err_q <= 1'b1;
                    end else begin
                        if (smp < min_q) min_q <= smp;
                        if (smp > max_q) max_q <= smp;
                    end
                end
            end
        end
    end

    // Saturating count of events lost to a full FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_q <= '0;
        else if (drop && drop_q != 8'hFF)
            drop_q <= drop_q + 8'd1;
    end

    cnt_mon_fifo #(
        .DEPTH (DEPTH),
        .W     (EV_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  ({ev_cls, cnt_i}),
        .pop_i   (ev_ready_i),
        .data_o  (ev_data_o),
        .empty_o (empty),
        .drop_o  (drop)
    );

    assign ev_valid_o = !empty;
    assign min_o      = min_q;
    assign max_o      = max_q;
    assign trk_vld_o  = trk_q;
    assign err_o      = err_q;
    assign drop_cnt_o = drop_q;

`ifdef STEP_STATS_EN
    logic [15:0] hold_q, jump_q, rev_q;
    logic        cnt_en;

    assign cnt_en = cnt_vld_i && !clr_i && (state_q != S_EMPTY);

    // Saturating per-class counters, independent of FIFO outcome
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            jump_q <= '0;
            rev_q  <= '0;
        end else if (clr_i) begin
            hold_q <= '0;
            jump_q <= '0;
            rev_q  <= '0;
        end else if (cnt_en) begin
            if (cls == C_HOLD && hold_q != 16'hFFFF)
                hold_q <= hold_q + 16'd1;
            if ((cls == C_JUP || cls == C_JDN) && jump_q != 16'hFFFF)
                jump_q <= jump_q + 16'd1;
            if (cls == C_REV && rev_q != 16'hFFFF)
                rev_q <= rev_q + 16'd1;
        end
    end

    assign hold_cnt_o = hold_q;
    assign jump_cnt_o = jump_q;
    assign rev_cnt_o  = rev_q;
`endif

endmodule
